// File: rtl/secded_encoder.sv
// SECDED (72,64) transmit-side encoder with a 2-entry elastic output buffer
// and a one-shot fault-injection path for end-to-end ECC exercising.

package SECDED_ECC_pkg;

  // Check bits for the (72,64) code. Data bits occupy the non-power-of-two
  // Hamming positions 3..71 in ascending order. check[6:0] are the Hamming
  // parities at positions 1,2,4,...,64. check[7] is the overall parity
  // across data and check[6:0].
  function automatic logic [7:0] mega_xor(input logic [63:0] data);
    logic [7:0] chk_v;
    logic [6:0] pos_v;
    logic [6:0] di_v;
    chk_v = 8'd0;
    di_v  = 7'd0;
    for (int p = 1; p < 72; p++) begin
      pos_v = p[6:0];
      if ((pos_v & (pos_v - 7'd1)) != 7'd0) begin
        for (int i = 0; i < 7; i++) begin
          if (pos_v[i]) begin
            chk_v[i] = chk_v[i] ^ data[di_v[5:0]];
          end else begin
            chk_v[i] = chk_v[i];
          end
        end
        di_v = di_v + 7'd1;
      end else begin
        di_v = di_v;
      end
    end
    chk_v[7] = ^{chk_v[6:0], data};
    return chk_v;
  endfunction

endpackage

module secded_encoder
  import SECDED_ECC_pkg::*;
#(
  parameter logic INJ_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [71:0] out_data,
  input  logic        inj_arm,
  input  logic [71:0] inj_mask,
  output logic        inj_pending,
  output logic [31:0] enc_count
);

  logic [1:0]  occ_q, occ_d;
  logic [71:0] head_q, head_d;
  logic [71:0] spare_q, spare_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic [31:0] enc_count_q, enc_count_d;
  logic        inj_pending_q, inj_pending_d;
  logic [71:0] inj_mask_q, inj_mask_d;

  logic        accept;
  logic        deliver;
  logic        arm;
  logic [71:0] applied_mask;
  logic [71:0] cw_in;

  // Handshake decode and the (possibly corrupted) codeword for this cycle.
  always_comb begin
    accept  = in_valid && (occ_q != 2'd2);
    deliver = (occ_q != 2'd0) && out_ready;
    arm     = INJ_EN && inj_arm;
    if (arm) begin
      applied_mask = inj_mask;
    end else if (INJ_EN && inj_pending_q) begin
      applied_mask = inj_mask_q;
    end else begin
      applied_mask = 72'd0;
    end
    cw_in = {mega_xor(in_data), in_data} ^ applied_mask;
  end

  // Injection mask bookkeeping: arm stores, first accepted word consumes.
  always_comb begin
    inj_pending_d = inj_pending_q;
    inj_mask_d    = inj_mask_q;
    if (arm && accept) begin
      inj_pending_d = 1'b0;
      inj_mask_d    = inj_mask;
    end else if (arm) begin
      inj_pending_d = 1'b1;
      inj_mask_d    = inj_mask;
    end else if (accept) begin
      inj_pending_d = 1'b0;
    end else begin
      inj_pending_d = inj_pending_q;
    end
    if (!INJ_EN) begin
      inj_pending_d = 1'b0;
      inj_mask_d    = 72'd0;
    end else begin
      inj_mask_d = inj_mask_d;
    end
  end

  // Two-entry buffer: head drives the output, spare holds the second word.
  always_comb begin
    occ_d       = occ_q;
    head_d      = head_q;
    spare_d     = spare_q;
    enc_count_d = enc_count_q;
    case ({accept, deliver})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = cw_in;
        end else begin
          spare_d = cw_in;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = spare_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Only reachable at occupancy 1: the new word replaces the head.
        head_d = cw_in;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
    if (deliver) begin
      enc_count_d = enc_count_q + 32'd1;
    end else begin
      enc_count_d = enc_count_q;
    end
    out_valid_d = (occ_d != 2'd0);
    in_ready_d  = (occ_d != 2'd2);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q         <= 2'd0;
      head_q        <= 72'd0;
      spare_q       <= 72'd0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      enc_count_q   <= 32'd0;
      inj_pending_q <= 1'b0;
      inj_mask_q    <= 72'd0;
    end else begin
      occ_q         <= occ_d;
      head_q        <= head_d;
      spare_q       <= spare_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
      enc_count_q   <= enc_count_d;
      inj_pending_q <= inj_pending_d;
      inj_mask_q    <= inj_mask_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign in_ready    = in_ready_q;
  assign out_data    = head_q;
  assign enc_count   = enc_count_q;
  assign inj_pending = inj_pending_q;

endmodule

// File: tb/tb_secded_encoder.sv
// Self-checking bench for secded_encoder: scoreboard of expected codewords
// plus a behavioural SECDED decoder for loopback checking.

module tb_secded_encoder;
  import SECDED_ECC_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_data;
  logic        inj_arm;
  logic [71:0] inj_mask;
  logic        inj_pending;
  logic [31:0] enc_count;

  logic        in_valid2;
  logic        in_ready2;
  logic [63:0] in_data2;
  logic        out_valid2;
  logic        out_ready2;
  logic [71:0] out_data2;
  logic        inj_arm2;
  logic [71:0] inj_mask2;
  logic        inj_pending2;
  logic [31:0] enc_count2;

  int checks;
  int errors;

  typedef struct {
    logic [71:0] cw;
    logic [71:0] mask;
    logic [63:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic        m_pend;
  logic [71:0] m_mask;
  logic [31:0] m_cnt;

  secded_encoder #(.INJ_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .inj_arm(inj_arm), .inj_mask(inj_mask),
    .inj_pending(inj_pending), .enc_count(enc_count)
  );

  secded_encoder #(.INJ_EN(1'b0)) dut_noinj (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .inj_arm(inj_arm2), .inj_mask(inj_mask2),
    .inj_pending(inj_pending2), .enc_count(enc_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural decoder working on Hamming positions (0 = overall parity).
  function automatic void tb_decode(input logic [71:0] cw, output logic se,
                                    output logic de, output logic [63:0] dout);
    logic [71:0] word;
    logic [6:0]  syn;
    logic        overall;
    int          d;
    int          ci;
    word = 72'd0;
    d = 0;
    ci = 0;
    word[0] = cw[71];
    for (int p = 1; p < 72; p++) begin
      if (p == 1 || p == 2 || p == 4 || p == 8 || p == 16 || p == 32 || p == 64) begin
        word[p] = cw[64 + ci];
        ci++;
      end else begin
        word[p] = cw[d];
        d++;
      end
    end
    syn = 7'd0;
    for (int p = 1; p < 72; p++) begin
      if (word[p]) syn = syn ^ p[6:0];
    end
    overall = ^word;
    se = overall;
    de = !overall && (syn != 7'd0);
    if (se && syn != 7'd0 && syn < 7'd72) word[syn] = ~word[syn];
    d = 0;
    dout = 64'd0;
    for (int p = 1; p < 72; p++) begin
      if (!(p == 1 || p == 2 || p == 4 || p == 8 || p == 16 || p == 32 || p == 64)) begin
        dout[d] = word[p];
        d++;
      end
    end
  endfunction

  // Scoreboard monitor: sampled at the falling edge, predicts the next rising edge.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic        se;
    logic        de;
    logic [63:0] dd;
    logic        acc;
    logic        dlv;
    int          n;
    if (rst) begin
      sb_q.delete();
      m_pend = 1'b0;
      m_mask = 72'd0;
      m_cnt  = 32'd0;
    end else begin
      checks++;
      if (out_valid !== (sb_q.size() != 0)) begin
        errors++;
        $display("FAIL sb_out_valid: got %b expected %b", out_valid, sb_q.size() != 0);
      end
      checks++;
      if (in_ready !== (sb_q.size() != 2)) begin
        errors++;
        $display("FAIL sb_in_ready: got %b expected %b", in_ready, sb_q.size() != 2);
      end
      checks++;
      if (inj_pending !== m_pend) begin
        errors++;
        $display("FAIL sb_inj_pending: got %b expected %b", inj_pending, m_pend);
      end
      checks++;
      if (enc_count !== m_cnt) begin
        errors++;
        $display("FAIL sb_enc_count: got %0d expected %0d", enc_count, m_cnt);
      end
      dlv = (sb_q.size() != 0) && out_ready;
      acc = in_valid && (sb_q.size() != 2);
      if (dlv) begin
        e = sb_q.pop_front();
        checks++;
        if (out_data !== e.cw) begin
          errors++;
          $display("FAIL sb_out_data: got %h expected %h", out_data, e.cw);
        end
        tb_decode(out_data, se, de, dd);
        n = $countones(e.mask);
        checks++;
        if (n == 0 && (se !== 1'b0 || de !== 1'b0 || dd !== e.data)) begin
          errors++;
          $display("FAIL loopback_clean: se=%b de=%b data %h expected %h", se, de, dd, e.data);
        end else if (n == 1 && (se !== 1'b1 || dd !== e.data)) begin
          errors++;
          $display("FAIL loopback_single: se=%b data %h expected se=1 data %h", se, dd, e.data);
        end else if (n == 2 && de !== 1'b1) begin
          errors++;
          $display("FAIL loopback_double: de=%b expected 1", de);
        end
        m_cnt = m_cnt + 32'd1;
      end
      if (acc) begin
        e.data = in_data;
        e.mask = inj_arm ? inj_mask : (m_pend ? m_mask : 72'd0);
        e.cw   = {mega_xor(in_data), in_data} ^ e.mask;
        sb_q.push_back(e);
        if (inj_arm) m_mask = inj_mask;
        m_pend = 1'b0;
      end else if (inj_arm) begin
        m_pend = 1'b1;
        m_mask = inj_mask;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    inj_arm   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || enc_count !== 32'd0 ||
        inj_pending !== 1'b0 || out_data !== 72'd0) begin
      errors++;
      $display("FAIL reset_values: ov=%b ir=%b cnt=%0d ip=%b od=%h expected 0 1 0 0 0",
               out_valid, in_ready, enc_count, inj_pending, out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_words();
    logic [63:0] ones;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'd0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 72'h0) begin
      errors++;
      $display("FAIL zero_word: ov=%b od=%h expected 1 %h", out_valid, out_data, 72'h0);
    end
    tick();
    in_valid = 1'b1;
    in_data  = ones;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== {mega_xor(ones), ones}) begin
      errors++;
      $display("FAIL ones_word: ov=%b od=%h expected %h", out_valid, out_data, {mega_xor(ones), ones});
    end
    drain();
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_rate: ir=%b ov=%b expected 1 1 at word %0d", in_ready, out_valid, i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (enc_count !== 32'd1000) begin
      errors++;
      $display("FAIL stream_count: got %0d expected 1000", enc_count);
    end
    drain();
  endtask

  task automatic test_loopback();
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      tick();
    end
    drain();
  endtask

  task automatic test_injection();
    logic [63:0] d;
    out_ready = 1'b1;
    inj_arm  = 1'b1;
    inj_mask = 72'h1;
    tick();
    inj_arm = 1'b0;
    checks++;
    if (inj_pending !== 1'b1) begin
      errors++;
      $display("FAIL inj_armed: got %b expected 1", inj_pending);
    end
    in_valid = 1'b1;
    in_data  = 64'd0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 72'h1 || inj_pending !== 1'b0) begin
      errors++;
      $display("FAIL inj_single: od=%h ip=%b expected %h 0", out_data, inj_pending, 72'h1);
    end
    inj_arm  = 1'b1;
    inj_mask = 72'h3;
    tick();
    inj_arm  = 1'b0;
    d = {$urandom, $urandom};
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== ({mega_xor(d), d} ^ 72'h3)) begin
      errors++;
      $display("FAIL inj_double: od=%h expected %h", out_data, {mega_xor(d), d} ^ 72'h3);
    end
    d = {$urandom, $urandom};
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== {mega_xor(d), d}) begin
      errors++;
      $display("FAIL inj_clean_after: od=%h expected %h", out_data, {mega_xor(d), d});
    end
    inj_arm  = 1'b1;
    inj_mask = 72'h10;
    tick();
    inj_mask = 72'h4;
    tick();
    inj_arm  = 1'b0;
    in_valid = 1'b1;
    in_data  = 64'd0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 72'h4) begin
      errors++;
      $display("FAIL inj_rearm: od=%h expected %h", out_data, 72'h4);
    end
    inj_arm  = 1'b1;
    inj_mask = 72'h100;
    in_valid = 1'b1;
    in_data  = 64'd0;
    tick();
    inj_arm  = 1'b0;
    checks++;
    if (out_data !== 72'h100 || inj_pending !== 1'b0) begin
      errors++;
      $display("FAIL inj_same_cycle: od=%h ip=%b expected %h 0", out_data, inj_pending, 72'h100);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 72'h0) begin
      errors++;
      $display("FAIL inj_same_cycle_next: od=%h expected %h", out_data, 72'h0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, c;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c = {$urandom, $urandom};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = a;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_one_entry: ir=%b expected 1", in_ready);
    end
    in_data = b;
    tick();
    in_data = c;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: ir=%b expected 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== {mega_xor(a), a}) begin
        errors++;
        $display("FAIL bp_stall: ir=%b ov=%b od=%h expected 0 1 %h", in_ready, out_valid, out_data, {mega_xor(a), a});
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_data !== {mega_xor(b), b}) begin
      errors++;
      $display("FAIL bp_release_b: ir=%b od=%h expected 1 %h", in_ready, out_data, {mega_xor(b), b});
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== {mega_xor(c), c} || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_c: ov=%b od=%h expected 1 %h", out_valid, out_data, {mega_xor(c), c});
    end
    drain();
  endtask

  task automatic test_wrap();
    force dut.enc_count_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.enc_count_q;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom};
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (enc_count !== 32'd0) begin
      errors++;
      $display("FAIL count_wrap: got %h expected 0", enc_count);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom};
    tick();
    in_data = {$urandom, $urandom};
    tick();
    in_valid = 1'b0;
    inj_arm  = 1'b1;
    inj_mask = 72'h5;
    tick();
    inj_arm = 1'b0;
    checks++;
    if (inj_pending !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_setup: ip=%b ov=%b ir=%b expected 1 1 0", inj_pending, out_valid, in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || inj_pending !== 1'b0 || in_ready !== 1'b1 || enc_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid: ov=%b ip=%b ir=%b cnt=%0d expected 0 0 1 0", out_valid, inj_pending, in_ready, enc_count);
    end
    d = {$urandom, $urandom};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== {mega_xor(d), d}) begin
      errors++;
      $display("FAIL rst_mid_mask_gone: od=%h expected %h", out_data, {mega_xor(d), d});
    end
    drain();
  endtask

  task automatic test_inj_disabled();
    logic [63:0] d;
    d = {$urandom, $urandom};
    inj_arm2  = 1'b1;
    inj_mask2 = 72'hFF;
    tick();
    inj_arm2 = 1'b0;
    checks++;
    if (inj_pending2 !== 1'b0) begin
      errors++;
      $display("FAIL noinj_pending: got %b expected 0", inj_pending2);
    end
    in_valid2 = 1'b1;
    in_data2  = d;
    tick();
    in_valid2 = 1'b0;
    checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== {mega_xor(d), d} || inj_pending2 !== 1'b0) begin
      errors++;
      $display("FAIL noinj_word: ov=%b od=%h ip=%b expected 1 %h 0", out_valid2, out_data2, inj_pending2, {mega_xor(d), d});
    end
    tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 64'd0;
    out_ready  = 1'b0;
    inj_arm    = 1'b0;
    inj_mask   = 72'd0;
    in_valid2  = 1'b0;
    in_data2   = 64'd0;
    out_ready2 = 1'b1;
    inj_arm2   = 1'b0;
    inj_mask2  = 72'd0;
    test_reset();
    test_basic_words();
    test_stream();
    test_loopback();
    test_injection();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_inj_disabled();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
